switch_hex_entry: RTL and testbench

Input-side companion to the hex display path on the 16-bit CPU FPGA top. Takes a 4-bit hex digit from slide switches and a bouncy active-low ENTER push-button, debounces the button, and shifts four digits (most significant first) into a 16-bit word. It presents the word to the CPU with a valid/ready handshake and exposes the partial entry so the top level can echo it on the seven-segment displays.

---
 rtl/cpu16_io_pkg.sv | 10 +
 rtl/button_debounce.sv | 45 ++++
 rtl/switch_hex_entry.sv | 99 +++++++++
 tb/tb_switch_hex_entry.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu16_io_pkg.sv
// Shared definitions for the CPU16 I/O front end: hex entry FSM states and word geometry.
package cpu16_io_pkg;

   typedef enum logic {COLLECT, FULL} entry_state_t;

   localparam int ENTRY_DIGITS = 4;
   localparam int HEX_W        = 4;
   localparam int WORD_W       = 16;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stable-sample debouncer and one-cycle press pulse for an
// active-low push-button.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_n,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // The pulse fires on the same edge the debounced level drops, so it is only
   // raised when the level being replaced is the released (1) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= raw_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST_CNT) begin
            level <= sync2;
            cnt   <= '0;
            press <= level;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/switch_hex_entry.sv
// Debounced four-digit hex entry from slide switches, offered to the CPU with valid/ready.
// Optional CLEAR button enabled by defining SWITCH_ENTRY_CLEAR_EN.
module switch_hex_entry
   import cpu16_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              KEY,
   input  logic [HEX_W-1:0]  SW,
   input  logic              btn_enter_n,
`ifdef SWITCH_ENTRY_CLEAR_EN
   input  logic              btn_clear_n,
`endif
   input  logic              data_ready,
   output logic [WORD_W-1:0] entry_word,
   output logic [2:0]        digit_count,
   output logic              data_valid
);

   entry_state_t      state;
   entry_state_t      next_state;
   logic [WORD_W-1:0] next_word;
   logic [2:0]        next_count;
   logic              next_valid;
   logic              enter_press;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
      .clk   (clk),
      .rst_n (KEY),
      .raw_n (btn_enter_n),
      .press (enter_press)
   );

`ifdef SWITCH_ENTRY_CLEAR_EN
   logic clear_press;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clk   (clk),
      .rst_n (KEY),
      .raw_n (btn_clear_n),
      .press (clear_press)
   );
`endif

   always_ff @(posedge clk or negedge KEY) begin
      if (!KEY) begin
         state       <= COLLECT;
         entry_word  <= '0;
         digit_count <= '0;
         data_valid  <= 1'b0;
      end else begin
         state       <= next_state;
         entry_word  <= next_word;
         digit_count <= next_count;
         data_valid  <= next_valid;
      end
   end

   // Presses in FULL are dropped, so a press landing on the handshake cycle is lost.
   always_comb begin
      next_state = state;
      next_word  = entry_word;
      next_count = digit_count;
      next_valid = data_valid;
      case (state)
         COLLECT: begin
            if (enter_press) begin
               next_word  = {entry_word[WORD_W-HEX_W-1:0], SW};
               next_count = digit_count + 3'd1;
               if (digit_count == 3'(ENTRY_DIGITS - 1)) begin
                  next_state = FULL;
                  next_valid = 1'b1;
               end
            end
         end
         FULL: begin
            if (data_valid && data_ready) begin
               next_state = COLLECT;
               next_word  = '0;
               next_count = '0;
               next_valid = 1'b0;
            end
         end
         default: begin
            next_state = COLLECT;
         end
      endcase
`ifdef SWITCH_ENTRY_CLEAR_EN
      if (clear_press) begin
         next_state = COLLECT;
         next_word  = '0;
         next_count = '0;
         next_valid = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_switch_hex_entry.sv
// Directed bench for switch_hex_entry with DEBOUNCE_CYCLES=4; covers the clear
// button when SWITCH_ENTRY_CLEAR_EN is defined.
module tb_switch_hex_entry;

   logic        clk;
   logic        KEY;
   logic [3:0]  SW;
   logic        btn_enter_n;
   logic        btn_clear_n;
   logic        data_ready;
   logic [15:0] entry_word;
   logic [2:0]  digit_count;
   logic        data_valid;

   int tests;
   int failures;

   typedef struct {
      logic [3:0]  sw;
      logic [15:0] exp_word;
      logic [2:0]  exp_count;
      logic        exp_valid;
   } vec_t;

   vec_t vecs[5];

   switch_hex_entry #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .KEY         (KEY),
      .SW          (SW),
      .btn_enter_n (btn_enter_n),
`ifdef SWITCH_ENTRY_CLEAR_EN
      .btn_clear_n (btn_clear_n),
`endif
      .data_ready  (data_ready),
      .entry_word  (entry_word),
      .digit_count (digit_count),
      .data_valid  (data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] w,
                              input logic [2:0] c, input logic v);
      tests++;
      if (entry_word !== w || digit_count !== c || data_valid !== v) begin
         failures++;
         $display("[TB] FAIL %s: got word=%h count=%0d valid=%b, expected word=%h count=%0d valid=%b",
                  name, entry_word, digit_count, data_valid, w, c, v);
      end
   endtask

   // Clean press: held low long enough to debounce, then released long enough to settle.
   task automatic applyStimulus(input logic [3:0] sw);
      @(negedge clk);
      SW = sw;
      btn_enter_n = 1'b0;
      repeat (10) @(negedge clk);
      btn_enter_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      KEY = 1'b0;
      repeat (3) @(negedge clk);
      KEY = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      tests = 0;
      failures = 0;
      KEY = 1'b0;
      SW = 4'h0;
      btn_enter_n = 1'b1;
      btn_clear_n = 1'b1;
      data_ready = 1'b0;

      vecs[0] = '{4'h1, 16'h0001, 3'd1, 1'b0};
      vecs[1] = '{4'h2, 16'h0012, 3'd2, 1'b0};
      vecs[2] = '{4'h3, 16'h0123, 3'd3, 1'b0};
      vecs[3] = '{4'h4, 16'h1234, 3'd4, 1'b1};
      vecs[4] = '{4'hF, 16'h1234, 3'd4, 1'b1};

      repeat (3) @(negedge clk);
      checkOutput("in_reset", 16'h0000, 3'd0, 1'b0);
      KEY = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("idle", 16'h0000, 3'd0, 1'b0);

      // Latency: pulse on the 6th edge after the press, outputs update on the 7th.
      SW = 4'h7;
      btn_enter_n = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("latency_edge6", 16'h0000, 3'd0, 1'b0);
      @(negedge clk);
      checkOutput("latency_edge7", 16'h0007, 3'd1, 1'b0);
      repeat (5) @(negedge clk);
      btn_enter_n = 1'b1;
      repeat (10) @(negedge clk);

      applyStimulus(4'h8);
      checkOutput("two_digits", 16'h0078, 3'd2, 1'b0);
      KEY = 1'b0;
      #1;
      checkOutput("async_reset_mid_entry", 16'h0000, 3'd0, 1'b0);
      repeat (2) @(negedge clk);
      KEY = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("after_reset_release", 16'h0000, 3'd0, 1'b0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].sw);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_count, vecs[i].exp_valid);
      end

      repeat (10) @(negedge clk);
      checkOutput("hold_without_ready", 16'h1234, 3'd4, 1'b1);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      checkOutput("handshake", 16'h0000, 3'd0, 1'b0);

      // data_ready while collecting has no effect.
      data_ready = 1'b1;
      applyStimulus(4'hA);
      data_ready = 1'b0;
      checkOutput("ready_in_collect", 16'h000A, 3'd1, 1'b0);
      applyStimulus(4'hB);
      applyStimulus(4'hC);
      applyStimulus(4'hD);
      checkOutput("refill", 16'hABCD, 3'd4, 1'b1);

      // Press pulse lands in the same cycle as the handshake.
      SW = 4'h9;
      btn_enter_n = 1'b0;
      repeat (6) @(negedge clk);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      checkOutput("press_with_handshake", 16'h0000, 3'd0, 1'b0);
      repeat (5) @(negedge clk);
      btn_enter_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("press_dropped", 16'h0000, 3'd0, 1'b0);

      // Bounce low 2 / high 1, then hold: one digit only.
      SW = 4'h5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         btn_enter_n = 1'b0;
         @(negedge clk);
         @(negedge clk);
         btn_enter_n = 1'b1;
      end
      @(negedge clk);
      btn_enter_n = 1'b0;
      repeat (10) @(negedge clk);
      btn_enter_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("bounce_one_digit", 16'h0005, 3'd1, 1'b0);

      SW = 4'h6;
      btn_enter_n = 1'b0;
      repeat (3) @(negedge clk);
      btn_enter_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("glitch3_rejected", 16'h0005, 3'd1, 1'b0);

`ifdef SWITCH_ENTRY_CLEAR_EN
      doReset();
      applyStimulus(4'hA);
      applyStimulus(4'hB);
      checkOutput("before_clear", 16'h00AB, 3'd2, 1'b0);
      SW = 4'hC;
      btn_enter_n = 1'b0;
      btn_clear_n = 1'b0;
      repeat (7) @(negedge clk);
      checkOutput("clear_beats_enter", 16'h0000, 3'd0, 1'b0);
      repeat (4) @(negedge clk);
      btn_enter_n = 1'b1;
      btn_clear_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("after_clear_release", 16'h0000, 3'd0, 1'b0);
`else
      doReset();
      checkOutput("final_reset", 16'h0000, 3'd0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
